// File: rtl/gensync_param.sv
// gensync_param: parametrised video timing generator with pixel clock-enable.
// Produces HSYNC/VSYNC, active-region flags, pixel coordinates and frame/line strobes.
//
// Ports:
//   CLK       in   system clock, all state on rising edge
//   reset     in   synchronous active-high reset (priority over CE)
//   CE        in   pixel enable; counters advance only when high
//   HSYNC     out  horizontal sync, active level HS_POL
//   VSYNC     out  vertical sync, active level VS_POL
//   IMG       out  pixel is inside the visible area
//   IMGY_out  out  line is inside the visible lines (including h-blanking)
//   X         out  visible column, 0 outside the active region
//   Y         out  visible row, 0 outside the active region
//   SOF       out  one-CLK strobe when counters land on (0,0)
//   SOL       out  one-CLK strobe when hcnt lands on 0
module gensync_param #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   XW       = 10,
    parameter int   YW       = 9
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          CE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          IMG,
    output logic          IMGY_out,
    output logic [XW-1:0] X,
    output logic [YW-1:0] Y,
    output logic          SOF,
    output logic          SOL
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    // H_BP >= 1 keeps the sync end strictly below H_TOTAL, so it fits in HW bits
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt;
    logic [HW-1:0] h_next;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] v_next;

    logic h_vis;
    logic v_vis;
    logic hs_on;
    logic vs_on;

    always_comb begin
        h_next = hcnt + HW'(1);
        v_next = vcnt;
        if (hcnt == H_LAST) begin
            h_next = '0;
            v_next = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end
    end

    // Outputs are decoded from the next-state counters so they register
    // on the same edge the counters move.
    always_comb begin
        h_vis = (h_next < H_ACT);
        v_vis = (v_next < V_ACT);
        hs_on = (h_next >= HS_BEG) && (h_next < HS_END);
        vs_on = (v_next >= VS_BEG) && (v_next < VS_END);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            // Parked on the last back-porch pixel: the first CE lands on (0,0)
            hcnt     <= H_LAST;
            vcnt     <= V_LAST;
            HSYNC    <= ~HS_POL;
            VSYNC    <= ~VS_POL;
            IMG      <= 1'b0;
            IMGY_out <= 1'b0;
            X        <= '0;
            Y        <= '0;
            SOF      <= 1'b0;
            SOL      <= 1'b0;
        end else if (CE) begin
            hcnt     <= h_next;
            vcnt     <= v_next;
            HSYNC    <= hs_on ? HS_POL : ~HS_POL;
            VSYNC    <= vs_on ? VS_POL : ~VS_POL;
            IMG      <= h_vis && v_vis;
            IMGY_out <= v_vis;
            X        <= h_vis ? XW'(h_next) : '0;
            Y        <= v_vis ? YW'(v_next) : '0;
            SOF      <= (h_next == '0) && (v_next == '0);
            SOL      <= (h_next == '0);
        end else begin
            // Levels hold; strobes last exactly one CLK
            SOF <= 1'b0;
            SOL <= 1'b0;
        end
    end

endmodule

// File: doc/gensync_param.md
# gensync_param

Parametrised video timing generator, successor to the fixed 640x480 `gensync`. Porch, sync and active widths plus sync polarities are configurable. It adds a pixel clock-enable and start-of-frame/start-of-line strobes. It drives the display port and supplies the pixel coordinates (X, Y) that the Z-buffer read-out and pixel pipeline use to address memory.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels); must be >= 1
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines); must be >= 1
- HS_POL, 0: HSYNC active level (0 = active-low)
- VS_POL, 0: VSYNC active level (0 = active-low)
- XW, 10: X width; H_ACTIVE <= 2^XW
- YW, 9: Y width; V_ACTIVE <= 2^YW
- CLK  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- CE  in  1  pixel enable; counters advance only on CLK edges where CE=1
- HSYNC  out  1  horizontal sync, level per HS_POL
- VSYNC  out  1  vertical sync, level per VS_POL
- IMG  out  1  1 when both hcnt and vcnt are in the active region
- IMGY_out  out  1  1 when vcnt is in the active region (whole line, including h-blanking)
- X  out  XW  hcnt when hcnt < H_ACTIVE, else 0
- Y  out  YW  vcnt when vcnt < V_ACTIVE, else 0
- SOF  out  1  one-CLK strobe: counters just advanced to (0,0)
- SOL  out  1  one-CLK strobe: hcnt just advanced to 0 (every line, including the frame's first)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters: hcnt is clog2(H_TOTAL) bits; vcnt is clog2(V_TOTAL) bits.
- Horizontal line layout in hcnt order: active 0..H_ACTIVE-1, front porch, sync, back porch.
  - HSYNC is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- Vertical frame layout follows the same order using vcnt.
  - VSYNC is active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - VSYNC changes only with vcnt, i.e. at the start of a line.
- Advance on CE=1:
  - If hcnt = H_TOTAL-1: hcnt <= 0 and vcnt <= (vcnt = V_TOTAL-1) ? 0 : vcnt+1.
  - Otherwise: hcnt <= hcnt+1.
- CE=0: counters and all level outputs hold; SOF and SOL are forced to 0.
- Reset loads hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1 (last back-porch pixel), so the first CE after reset lands on (0,0).
- Reset has priority over CE.
- Reset values of outputs:
  - HSYNC = ~HS_POL, VSYNC = ~VS_POL
  - IMG = 0, IMGY_out = 0, X = 0, Y = 0, SOF = 0, SOL = 0
- Reset mid-frame abandons the current frame. The next CE produces (0,0) with SOF=1; no partial-frame recovery.

## Timing
- All outputs are registered. They are computed from next-state counter values, so they change on the same edge as the counters. There is no combinational path from CE or reset to any output.
- Latency: the edge sampling CE=1 updates the counters and all outputs together.
- SOF and SOL are high for exactly one CLK, even when CE is held low afterwards.
- Default mode: H_TOTAL = 800, V_TOTAL = 525, 420000 CE cycles per frame. At 50 MHz CLK with CE toggling (25 MHz pixel rate), a frame is 16.8 ms.

## Test plan
- Reset, defaults: hold reset 2 cycles.
  - HSYNC = 1, VSYNC = 1, IMG = 0, IMGY_out = 0, X = 0, Y = 0, SOF = 0, SOL = 0.
- Continuous CE=1 after reset:
  - 1st CE: SOF = SOL = 1, X = 0, Y = 0, IMG = 1.
  - 640th CE: X = 639.
  - 641st CE: IMG = 0, X = 0.
  - HSYNC = 0 from the 657th through the 752nd CE.
  - 801st CE: SOL = 1, Y = 1.
- Full frame at defaults:
  - VSYNC = 0 exactly on vcnt 490 and 491.
  - IMGY_out = 0 for vcnt >= 480.
  - Second SOF on the 420001st CE.
- CE alternating 1/0: counters advance every other CLK; SOF and SOL are 1 CLK wide; X steps 0, 0, 1, 1, 2, ...
- Small instance H = 4/1/2/1, V = 3/1/1/1, HS_POL = 1, VS_POL = 1:
  - HSYNC = 1 on hcnt 5, 6.
  - VSYNC = 1 on vcnt 4.
  - SOF every 48 CEs; Y wraps 2 -> 0 across blanking.
- Reset mid-frame at (hcnt 300, vcnt 100) for 1 cycle: outputs return to reset values; the next CE gives SOF = 1, X = 0, Y = 0.
